ifetch_queue: RTL



---
 rtl/ifetch_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the PC, issues in-order word requests to
// instruction memory, buffers returned words with their PCs in a small FIFO
// and hands them to decode over a valid/ready handshake. A redirect flushes
// the FIFO and marks every in-flight fetch as stale so its response is dropped.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   fill_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] stale;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic          req_fire;
  logic          resp_live;
  logic          resp_drop;
  logic          pop;
  logic [CW:0]   inflight;
  logic [31:0]   redirect_target;
  logic          unused_redirect_lsbs;

  // Low address bits of a redirect target are ignored: fetches are word-aligned.
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit: queued entries plus in-flight requests never exceed the FIFO size,
  // so every non-stale response is guaranteed a free slot.
  assign inflight       = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = reset && (inflight < {1'b0, DEPTH_C}) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses belonging to fetches issued before a redirect are discarded.
  assign resp_live = imem_resp_valid && (stale == '0) && !redirect_valid;
  assign resp_drop = imem_resp_valid && (stale != '0) && !redirect_valid;

  // Head entry is combinational from storage; gated to zero while empty.
  assign id_valid = (count != '0) && !redirect_valid;
  assign pop      = id_valid && id_ready;
  assign id_pc    = (count != '0) ? pc_mem[rd_ptr]   : '0;
  assign id_inst  = (count != '0) ? inst_mem[rd_ptr] : '0;

  // Control state: PCs, FIFO pointers/occupancy, in-flight and stale counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      fetch_pc    <= RESET_PC;
      fill_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      stale       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_target;
      fill_pc     <= redirect_target;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      stale       <= stale + outstanding - CW'(imem_resp_valid);
      outstanding <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_live);
      if (resp_drop) begin
        stale <= stale - CW'(1);
      end
      if (resp_live) begin
        fill_pc <= fill_pc + 32'd4;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(resp_live) - CW'(pop);
    end
  end

  // FIFO storage write on a live response.
  // NOTE: storage is deliberately not reset; occupancy gates every read, so
  // stale contents are never observable and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (resp_live) begin
      pc_mem[wr_ptr]   <= fill_pc;
      inst_mem[wr_ptr] <= imem_resp_inst;
    end
  end

  // The credit scheme makes overflow unreachable; catch a broken invariant.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(resp_live && !pop && count == DEPTH_C));

endmodule
